// File: rtl/stack_alu_sequencer_if.sv
// Token, ALU and result channels between the stack ALU sequencer and its environment.
// The sequencer uses the slave modport; the feeder/ALU/consumer side uses master.
interface stack_alu_sequencer_if #(
  parameter int N           = 32,
  parameter int STACK_DEPTH = 8
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic               tok_valid;
  logic               tok_ready;
  logic [2:0]         tok_op;
  logic [N-1:0]       tok_data;
  logic [2:0]         alu_opcode;
  logic [N-1:0]       alu_input_data;
  logic [N-1:0]       alu_output_data;
  logic               alu_overflow;
  logic               res_valid;
  logic               res_ready;
  logic [N-1:0]       res_data;
  logic               res_overflow;
  logic               res_error;
  logic [DEPTH_W-1:0] depth;

  modport slave (
    input  tok_valid, tok_op, tok_data, alu_output_data, alu_overflow, res_ready,
    output tok_ready, alu_opcode, alu_input_data, res_valid, res_data,
           res_overflow, res_error, depth
  );

  modport master (
    output tok_valid, tok_op, tok_data, alu_output_data, alu_overflow, res_ready,
    input  tok_ready, alu_opcode, alu_input_data, res_valid, res_data,
           res_overflow, res_error, depth
  );
endinterface

// File: rtl/stack_alu_sequencer.sv
// Feeds (opcode, operand) tokens to the stack ALU one at a time, tracking stack depth and
// rejecting illegal tokens. Optional STACK_SEQ_PERF_EN adds ops_issued/err_count counters.
module stack_alu_sequencer #(
  parameter int N            = 32,
  parameter int STACK_DEPTH  = 8,
  parameter int ISSUE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stack_alu_sequencer_if.slave   bus
`ifdef STACK_SEQ_PERF_EN
  ,
  output logic [31:0]            ops_issued,
  output logic [15:0]            err_count
`endif
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int CNT_W   = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;

  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, RESULT} state_t;

  state_t             state;
  logic [2:0]         cur_op;
  logic [CNT_W-1:0]   issue_cnt;
  logic [DEPTH_W-1:0] depth_q;
  logic               tok_ready_q;
  logic [2:0]         alu_opcode_q;
  logic [N-1:0]       alu_input_data_q;
  logic               res_valid_q;
  logic [N-1:0]       res_data_q;
  logic               res_overflow_q;
  logic               res_error_q;
  logic               accept;
  logic               legal;

  function automatic logic is_legal(input logic [2:0] op, input logic [DEPTH_W-1:0] d);
    case (op)
      OP_PUSH:        is_legal = (32'(d) < STACK_DEPTH);
      OP_ADD, OP_MUL: is_legal = (32'(d) >= 2);
      OP_POP:         is_legal = (32'(d) >= 1);
      default:        is_legal = 1'b0;
    endcase
  endfunction

  assign accept = (state == IDLE) && bus.tok_valid && tok_ready_q;
  assign legal  = is_legal(bus.tok_op, depth_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cur_op           <= OP_IDLE;
      issue_cnt        <= '0;
      depth_q          <= '0;
      tok_ready_q      <= 1'b0;
      alu_opcode_q     <= OP_IDLE;
      alu_input_data_q <= '0;
      res_valid_q      <= 1'b0;
      res_data_q       <= '0;
      res_overflow_q   <= 1'b0;
      res_error_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tok_ready_q <= 1'b0;
            if (legal) begin
              alu_opcode_q <= bus.tok_op;
              cur_op       <= bus.tok_op;
              issue_cnt    <= '0;
              if (bus.tok_op == OP_PUSH) alu_input_data_q <= bus.tok_data;
              state        <= ISSUE;
            end else begin
              res_data_q     <= '0;
              res_overflow_q <= 1'b0;
              res_error_q    <= 1'b1;
              res_valid_q    <= 1'b1;
              state          <= RESULT;
            end
          end else begin
            // Raises tok_ready on the first edge after reset release.
            tok_ready_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_cnt == CNT_W'(ISSUE_CYCLES - 1)) begin
            alu_opcode_q <= OP_IDLE;
            state        <= GAP;
            if (cur_op == OP_PUSH) begin
              depth_q <= depth_q + 1'b1;
            end else begin
              depth_q        <= depth_q - 1'b1;
              res_data_q     <= bus.alu_output_data;
              res_overflow_q <= (cur_op == OP_POP) ? 1'b0 : bus.alu_overflow;
              res_error_q    <= 1'b0;
            end
          end else begin
            issue_cnt <= issue_cnt + 1'b1;
          end
        end
        GAP: begin
          if (cur_op == OP_PUSH) begin
            tok_ready_q <= 1'b1;
            state       <= IDLE;
          end else begin
            res_valid_q <= 1'b1;
            state       <= RESULT;
          end
        end
        RESULT: begin
          if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
            tok_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STACK_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_issued <= '0;
      err_count  <= '0;
    end else if (accept) begin
      if (legal && ops_issued != '1) ops_issued <= ops_issued + 1'b1;
      if (!legal && err_count != '1) err_count <= err_count + 1'b1;
    end
  end
`endif

  assign bus.tok_ready      = tok_ready_q;
  assign bus.alu_opcode     = alu_opcode_q;
  assign bus.alu_input_data = alu_input_data_q;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_data       = res_data_q;
  assign bus.res_overflow   = res_overflow_q;
  assign bus.res_error      = res_error_q;
  assign bus.depth          = depth_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Directed plus randomized bench for stack_alu_sequencer with a stub stack ALU
// and a queue-based reference model of the expected results and depth.
module tb_stack_alu_sequencer;
  localparam int N  = 32;
  localparam int SD = 8;
  localparam int IC = 1;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  stack_alu_sequencer_if #(.N(N), .STACK_DEPTH(SD)) bus ();

`ifdef STACK_SEQ_PERF_EN
  logic [31:0] ops_issued;
  logic [15:0] err_count;
  stack_alu_sequencer #(.N(N), .STACK_DEPTH(SD), .ISSUE_CYCLES(IC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ops_issued(ops_issued), .err_count(err_count));
`else
  stack_alu_sequencer #(.N(N), .STACK_DEPTH(SD), .ISSUE_CYCLES(IC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub stack ALU: combinational result from the top two entries, stack updated on the op edge.
  logic [31:0] stk [0:15];
  logic [3:0]  sp;
  longint      sa, sb, sr;

  always_comb begin
    sa = 0;
    sb = 0;
    sr = 0;
    if (sp >= 4'd1) sa = longint'($signed(stk[sp - 4'd1]));
    if (sp >= 4'd2) sb = longint'($signed(stk[sp - 4'd2]));
    case (bus.alu_opcode)
      3'b100:  sr = sa + sb;
      3'b101:  sr = sa * sb;
      default: sr = sa;
    endcase
    bus.alu_output_data = sr[31:0];
    bus.alu_overflow    = (bus.alu_opcode == 3'b100 || bus.alu_opcode == 3'b101) &&
                          (sr != longint'($signed(sr[31:0])));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= 4'd0;
    end else begin
      case (bus.alu_opcode)
        3'b110: begin stk[sp] <= bus.alu_input_data; sp <= sp + 4'd1; end
        3'b100, 3'b101: begin stk[sp - 4'd2] <= sr[31:0]; sp <= sp - 4'd1; end
        3'b111: sp <= sp - 4'd1;
        default: ;
      endcase
    end
  end

  // Reference model: the stack as a queue, top at the back.
  logic [31:0] q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (bus.tok_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("tok_ready_wait", 64'(bus.tok_ready), 64'd1);
  endtask

  task automatic run_tok(input logic [2:0] op, input logic [31:0] data, input int hold,
                         output logic [31:0] got_data, output logic got_ovf);
    bit          legal;
    logic [31:0] ed, a, b, sd;
    logic        eo;
    longint      r;
    int          n, d0;
    n  = q.size();
    d0 = n;
    legal = (op == 3'b110 && n < SD) || ((op == 3'b100 || op == 3'b101) && n >= 2) ||
            (op == 3'b111 && n >= 1);
    ed = 32'd0;
    eo = 1'b0;
    if (legal) begin
      case (op)
        3'b110: q.push_back(data);
        3'b111: ed = q.pop_back();
        default: begin
          a = q.pop_back();
          b = q.pop_back();
          if (op == 3'b100) r = longint'($signed(a)) + longint'($signed(b));
          else              r = longint'($signed(a)) * longint'($signed(b));
          ed = r[31:0];
          eo = (r > 64'sd2147483647) || (r < -64'sd2147483648);
          q.push_back(ed);
        end
      endcase
    end
    got_data = 32'd0;
    got_ovf  = 1'b0;

    wait_ready();
    bus.tok_valid = 1'b1;
    bus.tok_op    = op;
    bus.tok_data  = data;
    @(negedge clk);
    bus.tok_valid = 1'b0;
    bus.tok_op    = 3'($urandom);
    bus.tok_data  = $urandom;

    if (legal) begin
      for (int i = 0; i < IC; i++) begin
        chk("issue_opcode", 64'(bus.alu_opcode), 64'(op));
        chk("issue_tok_ready", 64'(bus.tok_ready), 64'd0);
        @(negedge clk);
      end
      chk("gap_opcode", 64'(bus.alu_opcode), 64'd0);
      chk("gap_depth", 64'(bus.depth), 64'(q.size()));
      @(negedge clk);
      if (op == 3'b110) begin
        chk("push_tok_ready", 64'(bus.tok_ready), 64'd1);
        chk("push_res_valid", 64'(bus.res_valid), 64'd0);
        return;
      end
    end else begin
      chk("rej_opcode", 64'(bus.alu_opcode), 64'd0);
      chk("rej_depth", 64'(bus.depth), 64'(d0));
    end

    chk("res_valid", 64'(bus.res_valid), 64'd1);
    chk("res_data", 64'(bus.res_data), 64'(ed));
    chk("res_overflow", 64'(bus.res_overflow), 64'(eo));
    chk("res_error", 64'(bus.res_error), 64'(!legal));
    chk("res_tok_ready", 64'(bus.tok_ready), 64'd0);
    got_data = bus.res_data;
    got_ovf  = bus.res_overflow;
    sd       = bus.res_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.res_valid), 64'd1);
      chk("hold_data", 64'(bus.res_data), 64'(sd));
      chk("hold_error", 64'(bus.res_error), 64'(!legal));
      chk("hold_tok_ready", 64'(bus.tok_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("release_valid", 64'(bus.res_valid), 64'd0);
    chk("release_tok_ready", 64'(bus.tok_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] gd;
    logic        go;
    logic [2:0]  rop;
    bus.tok_valid = 1'b0;
    bus.tok_op    = 3'b000;
    bus.tok_data  = 32'd0;
    bus.res_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_opcode", 64'(bus.alu_opcode), 64'd0);
    chk("rst_input_data", 64'(bus.alu_input_data), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_data", 64'(bus.res_data), 64'd0);
    chk("rst_res_error", 64'(bus.res_error), 64'd0);
    chk("rst_depth", 64'(bus.depth), 64'd0);
    chk("rst_tok_ready", 64'(bus.tok_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_tok(3'b110, 32'd10, 0, gd, go);
    run_tok(3'b110, 32'd20, 0, gd, go);
    run_tok(3'b100, 32'd0, 0, gd, go);
    chk("plan_add_30", 64'(gd), 64'd30);
    run_tok(3'b110, 32'd3, 0, gd, go);
    run_tok(3'b110, 32'd4, 0, gd, go);
    run_tok(3'b101, 32'd0, 0, gd, go);
    chk("plan_mul_12", 64'(gd), 64'd12);
    run_tok(3'b111, 32'd0, 0, gd, go);
    chk("plan_pop_12", 64'(gd), 64'd12);
    run_tok(3'b110, 32'h7FFFFFFF, 0, gd, go);
    run_tok(3'b110, 32'd1, 0, gd, go);
    run_tok(3'b100, 32'd0, 0, gd, go);
    chk("plan_add_ovf_data", 64'(gd), 64'h80000000);
    chk("plan_add_ovf_flag", 64'(go), 64'd1);
    run_tok(3'b110, 32'h80000000, 0, gd, go);
    run_tok(3'b110, 32'd2, 0, gd, go);
    run_tok(3'b101, 32'd0, 0, gd, go);
    chk("plan_mul_ovf_flag", 64'(go), 64'd1);
    // Down to one entry, then illegal add and illegal opcode 010.
    while (q.size() > 1) run_tok(3'b111, 32'd0, 0, gd, go);
    run_tok(3'b100, 32'd0, 0, gd, go);
    run_tok(3'b010, 32'd55, 0, gd, go);
    while (q.size() < SD) run_tok(3'b110, $urandom, 0, gd, go);
    chk("full_depth", 64'(bus.depth), 64'(SD));
    run_tok(3'b110, 32'd99, 0, gd, go);
    run_tok(3'b100, 32'd0, 5, gd, go);

    // Reset in the middle of a mul issue.
    wait_ready();
    bus.tok_valid = 1'b1;
    bus.tok_op    = 3'b101;
    @(negedge clk);
    bus.tok_valid = 1'b0;
    chk("mid_issue_opcode", 64'(bus.alu_opcode), 64'b101);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_opcode", 64'(bus.alu_opcode), 64'd0);
    chk("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("mid_rst_depth", 64'(bus.depth), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_tok(3'b110, 32'd5, 0, gd, go);
    run_tok(3'b111, 32'd0, 0, gd, go);
    chk("post_rst_pop_5", 64'(gd), 64'd5);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rop = 3'b110;
        4:          rop = 3'b100;
        5:          rop = 3'b101;
        6, 7:       rop = 3'b111;
        default:    rop = 3'($urandom_range(0, 7));
      endcase
      run_tok(rop, ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 200)) : $urandom,
              $urandom_range(0, 2), gd, go);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
